// File: rtl/argmax_stream_10_16.sv
// argmax_stream_10_16
//   Classifier tail stage. Collects one vector of M signed T-bit activations,
//   one element per accepted beat, then presents the index and value of the
//   largest element on a registered result stream. When elements tie, the
//   lower index wins.
//
// Ports
//   clk       single clock, posedge
//   reset     synchronous, active-high, overrides every other update
//   s_valid   upstream element valid
//   s_ready   block accepts an element this cycle (registered)
//   data_in   signed element
//   m_valid   result valid (registered)
//   m_ready   downstream accepts the result
//   data_out  index of the maximum element (0..M-1)
//   max_out   signed value of the maximum element
module argmax_stream_10_16 #(
  parameter int M  = 10,
  parameter int T  = 16,
  parameter int IW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [T-1:0]  data_in,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [IW-1:0] data_out,
  output logic [T-1:0]  max_out
);

  typedef enum logic {COLLECT, HOLD} state_e;

  localparam logic [IW-1:0] LAST = IW'(M - 1);

  state_e              state_q;
  logic [IW-1:0]       cnt_q;
  logic [IW-1:0]       idx_q, idx_d;
  logic signed [T-1:0] max_q, max_d;
  logic                s_ready_q, m_valid_q;
  logic [IW-1:0]       data_out_q;
  logic [T-1:0]        max_out_q;
  logic                accept, take;

  assign accept = s_valid && s_ready_q && (state_q == COLLECT);

  // Element 0 always seeds the running max. After that, only a strictly
  // larger value replaces it, so an earlier index keeps a tie.
  always_comb begin
    take  = (cnt_q == '0) || ($signed(data_in) > max_q);
    max_d = take ? $signed(data_in) : max_q;
    idx_d = take ? cnt_q : idx_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= COLLECT;
      cnt_q      <= '0;
      idx_q      <= '0;
      max_q      <= '0;
      s_ready_q  <= 1'b1;
      m_valid_q  <= 1'b0;
      data_out_q <= '0;
      max_out_q  <= '0;
    end else begin
      unique case (state_q)
        COLLECT: begin
          if (accept) begin
            max_q <= max_d;
            idx_q <= idx_d;
            if (cnt_q == LAST) begin
              // The result includes the update from this last beat.
              cnt_q      <= '0;
              state_q    <= HOLD;
              s_ready_q  <= 1'b0;
              m_valid_q  <= 1'b1;
              data_out_q <= idx_d;
              max_out_q  <= max_d;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        HOLD: begin
          // Input is ignored here. Result registers keep their values after
          // the handshake.
          if (m_valid_q && m_ready) begin
            m_valid_q <= 1'b0;
            s_ready_q <= 1'b1;
            state_q   <= COLLECT;
          end
        end
      endcase
    end
  end

  assign s_ready  = s_ready_q;
  assign m_valid  = m_valid_q;
  assign data_out = data_out_q;
  assign max_out  = max_out_q;

endmodule

// File: tb/tb_argmax_stream_10_16.sv
module tb_argmax_stream_10_16;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] data_in;
  logic        m_valid;
  logic        m_ready;
  logic [3:0]  data_out;
  logic [15:0] max_out;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_idx, exp_max;
  int mv_cycles = 0;
  logic signed [15:0] vec [10];

  argmax_stream_10_16 #(.M(10), .T(16), .IW(4)) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .data_in(data_in),
    .m_valid(m_valid), .m_ready(m_ready),
    .data_out(data_out), .max_out(max_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (m_valid) mv_cycles++;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // The reference result is the first position that holds the largest value.
  task automatic ref_model;
    int best = 0;
    for (int i = 1; i < 10; i++)
      if (int'(vec[i]) > int'(vec[best])) best = i;
    exp_idx = best;
    exp_max = int'(vec[best]);
  endtask

  function automatic logic signed [15:0] rnd_val();
    case ($urandom_range(3))
      0: return 16'sh8000;
      1: return 16'sh7FFF;
      2: return 16'(int'($urandom_range(6)) - 3);
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic send_vec(input int gap_pct);
    for (int i = 0; i < 10; i++) begin
      int gaps = 0;
      while (gaps < 3 && $urandom_range(99) < gap_pct) begin
        s_valid = 1'b0;
        data_in = 16'($urandom);
        tick;
        chk("rdy_gap", int'(s_ready), 1);
        chk("mv_gap", int'(m_valid), 0);
        gaps++;
      end
      s_valid = 1'b1;
      data_in = vec[i];
      chk("rdy_beat", int'(s_ready), 1);
      tick;
    end
    s_valid = 1'b0;
    ref_model;
    chk("mv_rise", int'(m_valid), 1);
    chk("rdy_hold", int'(s_ready), 0);
    chk("idx", int'(data_out), exp_idx);
    chk("max", int'($signed(max_out)), exp_max);
  endtask

  task automatic take_result(input int stall);
    for (int s = 0; s < stall; s++) begin
      m_ready = 1'b0;
      s_valid = 1'b1;
      data_in = 16'($urandom);
      tick;
      chk("mv_stall", int'(m_valid), 1);
      chk("rdy_stall", int'(s_ready), 0);
      chk("idx_stall", int'(data_out), exp_idx);
      chk("max_stall", int'($signed(max_out)), exp_max);
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    tick;
    chk("mv_fall", int'(m_valid), 0);
    chk("rdy_rise", int'(s_ready), 1);
    m_ready = 1'b0;
  endtask

  initial begin
    int mv0;
    reset = 1'b1; s_valid = 1'b0; m_ready = 1'b0; data_in = '0;
    tick; tick;
    reset = 1'b0;
    chk("rst_rdy", int'(s_ready), 1);
    chk("rst_mv", int'(m_valid), 0);
    chk("rst_idx", int'(data_out), 0);
    chk("rst_max", int'($signed(max_out)), 0);

    // A tie at index 4 loses to index 3.
    vec = '{0, 5, 3, 9, 9, 1, 0, 2, 8, 4};
    send_vec(0);
    chk("t1_idx", int'(data_out), 3);
    chk("t1_max", int'($signed(max_out)), 9);
    take_result(0);

    vec = '{-5, -3, -32768, -3, -7, -100, -4, -9, -1000, -20};
    send_vec(0);
    chk("neg_idx", int'(data_out), 1);
    chk("neg_max", int'($signed(max_out)), -3);
    take_result(2);

    vec = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    send_vec(30);
    chk("zero_idx", int'(data_out), 0);
    chk("zero_max", int'($signed(max_out)), 0);
    take_result(0);

    vec = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 127};
    send_vec(50);
    chk("last_idx", int'(data_out), 9);
    chk("last_max", int'($signed(max_out)), 127);
    take_result(5);

    // If any stalled beat had been consumed, this result would be wrong.
    vec = '{7, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    send_vec(0);
    chk("bp_idx", int'(data_out), 0);
    chk("bp_max", int'($signed(max_out)), 7);
    take_result(0);

    // Reset in the middle of a vector clears all partial state.
    for (int i = 0; i < 6; i++) begin
      s_valid = 1'b1;
      data_in = (i == 2) ? 16'sh7FFF : 16'sd50;
      tick;
    end
    s_valid = 1'b0;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("mrst_rdy", int'(s_ready), 1);
    chk("mrst_mv", int'(m_valid), 0);
    chk("mrst_idx", int'(data_out), 0);
    chk("mrst_max", int'($signed(max_out)), 0);
    for (int i = 0; i < 10; i++) vec[i] = 16'(int'($urandom_range(200)) - 100);
    send_vec(20);
    take_result(1);

    // Three vectors back to back with the result side always ready.
    mv0 = mv_cycles;
    m_ready = 1'b1;
    for (int v = 0; v < 3; v++) begin
      for (int i = 0; i < 10; i++) vec[i] = rnd_val();
      send_vec(0);
      tick;
      chk("b2b_mv_fall", int'(m_valid), 0);
      chk("b2b_rdy", int'(s_ready), 1);
    end
    m_ready = 1'b0;
    chk("b2b_pulses", mv_cycles - mv0, 3);

    // Random vectors with random gaps and random back-pressure.
    for (int v = 0; v < 25; v++) begin
      for (int i = 0; i < 10; i++) vec[i] = rnd_val();
      send_vec(int'($urandom_range(60)));
      take_result(int'($urandom_range(4)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
